// File: rtl/arbiter_rr_8_1.sv
// Round-robin 8:1 arbiter driving the shared mux select and valid flag.
// Define ARB_TIMEOUT_EN to pre-empt owners after MAX_HOLD cycles.
module arbiter_rr_8_1 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] seleksioni,
  output logic       valid,
  output logic       owner_changed
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       timeout_pulse
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_d;
  logic [2:0]       ptr, ptr_d;
  logic [CNT_W-1:0] hold, hold_d;
  logic [7:0]       grant_d;
  logic [2:0]       sel_d;
  logic             valid_d;
  logic             oc_d;
  logic             tmo;
  logic             tp_d;
  logic             rel;
  logic [2:0]       win;
  logic [2:0]       idx;
  logic             hit;

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_chk
    $error("arbiter_rr_8_1: bad MAX_HOLD/CNT_W");
  end

  // ptr always holds the last owner, so one scan serves idle and re-arbitration
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign tmo = (state == GRANT) &&
               (hold == CNT_W'(MAX_HOLD));
`else
  assign tmo = 1'b0;
`endif

  assign rel = done | ~req[seleksioni] | tmo;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    grant_d = grant;
    sel_d   = seleksioni;
    valid_d = valid;
    oc_d    = 1'b0;
    tp_d    = 1'b0;
    hold_d  = (&hold) ? hold : hold + 1'b1;
    unique case (state)
      IDLE: begin
        hold_d = '0;
        if (hit) begin
          state_d = GRANT;
          grant_d = 8'b1 << win;
          sel_d   = win;
          valid_d = 1'b1;
          oc_d    = 1'b1;
          ptr_d   = win;
          hold_d  = CNT_W'(1);
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (rel) begin
          tp_d = tmo;
          if (hit) begin
            grant_d = 8'b1 << win;
            sel_d   = win;
            valid_d = 1'b1;
            oc_d    = 1'b1;
            ptr_d   = win;
            hold_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 3'd7;
      hold          <= '0;
      grant         <= '0;
      seleksioni    <= '0;
      valid         <= 1'b0;
      owner_changed <= 1'b0;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      hold          <= hold_d;
      grant         <= grant_d;
      seleksioni    <= sel_d;
      valid         <= valid_d;
      owner_changed <= oc_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_pulse <= 1'b0;
    else        timeout_pulse <= tp_d;
  end
`else
  logic unused_tp;
  assign unused_tp = tp_d;
`endif

endmodule

// File: tb/tb_arbiter_rr_8_1.sv
// Scoreboard bench for arbiter_rr_8_1.
// Build with ARB_TIMEOUT_EN to also exercise pre-emption (MAX_HOLD=4).
module tb_arbiter_rr_8_1;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] seleksioni;
  logic       valid;
  logic       owner_changed;
  logic       tp;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       oc;
    logic       tp;
  } exp_t;

  exp_t sbq[$];

  int         m_busy;
  int         m_ptr;
  logic [7:0] m_grant;
  logic [2:0] m_sel;
  logic       m_valid;
  int         m_hold;

  always #5 clk = ~clk;

  arbiter_rr_8_1 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .seleksioni    (seleksioni),
    .valid         (valid),
    .owner_changed (owner_changed)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_pulse (tp)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign tp = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy  = 0;
    m_ptr   = 7;
    m_grant = '0;
    m_sel   = '0;
    m_valid = 1'b0;
    m_hold  = 0;
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    exp_t e;
    exp_t o;
    int   w;
    bit   to;
    bit   rel;
    req  = r;
    done = d;
    e.oc = 1'b0;
    e.tp = 1'b0;
    to   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to = (m_busy != 0) && (m_hold == MH);
`endif
    rel = (m_busy == 0) || d || !r[m_sel] || to;
    if (rel) begin
      if (m_busy != 0) e.tp = to;
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_busy  = 1;
        m_ptr   = w;
        m_sel   = 3'(w);
        m_grant = '0;
        m_grant[w] = 1'b1;
        m_valid = 1'b1;
        m_hold  = 1;
        e.oc    = 1'b1;
      end else begin
        m_busy  = 0;
        m_grant = '0;
        m_valid = 1'b0;
        m_hold  = 0;
      end
    end else if (m_hold < 255) begin
      m_hold++;
    end
    e.g = m_grant;
    e.s = m_sel;
    e.v = m_valid;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    o = sbq.pop_front();
    chk("grant", 32'(grant), 32'(o.g));
    chk("sel", 32'(seleksioni), 32'(o.s));
    chk("valid", 32'(valid), 32'(o.v));
    chk("owner_changed", 32'(owner_changed), 32'(o.oc));
`ifdef ARB_TIMEOUT_EN
    chk("timeout_pulse", 32'(tp), 32'(o.tp));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    m_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_sel", 32'(seleksioni), 32'h0);
    chk("rst_oc", 32'(owner_changed), 32'h0);
    chk("rst_tp", 32'(tp), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req   = '0;
    done  = 1'b0;
    #3;
    do_reset();

    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);

    for (int i = 0; i < 27; i++) step(8'hFF, (i % 3) == 2);

    do_reset();
    step(8'h20, 1'b0);
    step(8'h24, 1'b1);
    step(8'h04, 1'b0);

    step(8'h08, 1'b0);
    step(8'h08, 1'b1);
    step(8'h08, 1'b0);
    step(8'h08, 1'b1);

    do_reset();
    for (int i = 0; i < 12; i++) step(8'h03, 1'b0);

    do_reset();
    step(8'h40, 1'b0);
    step(8'h40, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h41, 1'b0);
    step(8'h41, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step(8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

endmodule
